// File: rtl/me_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : me_run_ctrl_if
//  Description : Four-phase req/ack handshake plus result bus between the
//                run controller (master) and the motion-estimation core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface me_run_ctrl_if #(
  parameter int SAD_W  = 16,
  parameter int MVEC_W = 12
);
  logic              req;
  logic              ack;
  logic [SAD_W-1:0]  min_sad;
  logic [MVEC_W-1:0] min_mvec;

  // Controller side: issues req, receives ack and results
  modport master (output req, input ack, input min_sad, input min_mvec);
  // ME core side: answers req with ack and results
  modport slave  (input req, output ack, output min_sad, output min_mvec);
endinterface
`default_nettype wire

// File: rtl/me_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : me_run_ctrl
//  Description : Debounces push-buttons into falling-edge pulses and runs a
//                batch of ME requests over a four-phase handshake with
//                timeout and abort, holding last and best SAD/mvec results.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_run_ctrl #(
  parameter int NUM_SW       = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SAD_W        = 16,
  parameter int MVEC_W       = 12,
  parameter int RUNS_W       = 8,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_n,
  input  logic [RUNS_W-1:0] run_cnt,
  output logic [NUM_SW-1:0] sw_fall,
  me_run_ctrl_if.master     me,
  output logic [SAD_W-1:0]  last_sad,
  output logic [MVEC_W-1:0] last_mvec,
  output logic [SAD_W-1:0]  best_sad,
  output logic [MVEC_W-1:0] best_mvec,
  output logic [RUNS_W-1:0] runs_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // REL_END releases the handshake and then ends the batch (abort or timeout)
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_REL     = 2'd2;
  localparam logic [1:0] S_REL_END = 2'd3;

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      logic            sync1;
      logic            sync2;
      logic            deb;
      logic            deb_d;
      logic            fall;
      logic [DB_W-1:0] cnt;

      // Synchronise, require a stable differing level, then pulse on 1->0
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b1;
          sync2 <= 1'b1;
          deb   <= 1'b1;
          deb_d <= 1'b1;
          fall  <= 1'b0;
          cnt   <= '0;
        end else begin
          sync1 <= sw_n[gi];
          sync2 <= sync1;
          deb_d <= deb;
          fall  <= deb_d & ~deb;
          if (sync2 == deb) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            deb <= sync2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign sw_fall[gi] = fall;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Run controller
  // --------------------------------------------------------------------------
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [TO_W-1:0]   tcnt;
  logic [RUNS_W-1:0] target;
  logic              start_ev;
  logic              abort_ev;
  logic              clear_ev;
  logic              tout_hit;
  logic              do_start;
  logic              do_clear;
  logic              do_capture;
  logic              do_timeout;

  assign start_ev = sw_fall[0];
  assign abort_ev = sw_fall[1];
  assign clear_ev = sw_fall[2];
  assign tout_hit = (tcnt == TO_LAST);
  assign busy     = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort outranks ack, ack outranks timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ev) state_nxt = S_REQ;
      S_REQ: begin
        if (abort_ev)         state_nxt = S_REL_END;
        else if (me.ack)      state_nxt = S_REL;
        else if (tout_hit)    state_nxt = S_REL_END;
      end
      S_REL: begin
        if (abort_ev)         state_nxt = S_REL_END;
        else if (!me.ack) begin
          if ((target != '0) && (runs_done == target)) state_nxt = S_IDLE;
          else                                         state_nxt = S_REQ;
        end
      end
      S_REL_END: if (!me.ack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Action strobes for the datapath; start wins over clear in IDLE
  always_comb begin
    do_start   = 1'b0;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        do_start = start_ev;
        do_clear = clear_ev & ~start_ev;
      end
      S_REQ: begin
        do_capture = me.ack & ~abort_ev;
        do_timeout = ~me.ack & ~abort_ev & tout_hit;
      end
      default: ;
    endcase
  end

  // Registered req tracks REQ occupancy; timeout counter restarts per request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me.req <= 1'b0;
      tcnt   <= '0;
    end else begin
      me.req <= (state_nxt == S_REQ);
      if ((state == S_REQ) && (state_nxt == S_REQ)) tcnt <= tcnt + 1'b1;
      else                                          tcnt <= '0;
    end
  end

  // Result capture, batch bookkeeping and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target      <= '0;
      runs_done   <= '0;
      last_sad    <= '0;
      last_mvec   <= '0;
      best_sad    <= '1;
      best_mvec   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (do_start) begin
        target      <= run_cnt;
        runs_done   <= '0;
        best_sad    <= '1;
        best_mvec   <= '0;
        timeout_err <= 1'b0;
      end
      if (do_clear) begin
        runs_done   <= '0;
        last_sad    <= '0;
        last_mvec   <= '0;
        best_sad    <= '1;
        best_mvec   <= '0;
        timeout_err <= 1'b0;
      end
      if (do_capture) begin
        last_sad  <= me.min_sad;
        last_mvec <= me.min_mvec;
        runs_done <= runs_done + 1'b1;
        if (me.min_sad < best_sad) begin
          best_sad  <= me.min_sad;
          best_mvec <= me.min_mvec;
        end
      end
      if (do_timeout) timeout_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_me_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_run_ctrl
//  Description : Directed self-checking bench for me_run_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_run_ctrl;

  localparam int NUM_SW = 4;
  localparam int DEB    = 4;
  localparam int SAD_W  = 16;
  localparam int MVEC_W = 12;
  localparam int RUNS_W = 8;
  localparam int TOUT   = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_SW-1:0] sw_n;
  logic [RUNS_W-1:0] run_cnt;
  logic [NUM_SW-1:0] sw_fall;
  logic [SAD_W-1:0]  last_sad;
  logic [MVEC_W-1:0] last_mvec;
  logic [SAD_W-1:0]  best_sad;
  logic [MVEC_W-1:0] best_mvec;
  logic [RUNS_W-1:0] runs_done;
  logic              busy;
  logic              timeout_err;

  me_run_ctrl_if #(.SAD_W(SAD_W), .MVEC_W(MVEC_W)) bus ();

  me_run_ctrl #(
    .NUM_SW(NUM_SW), .DEBOUNCE_CYC(DEB), .SAD_W(SAD_W), .MVEC_W(MVEC_W),
    .RUNS_W(RUNS_W), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_n(sw_n), .run_cnt(run_cnt),
    .sw_fall(sw_fall), .me(bus.master),
    .last_sad(last_sad), .last_mvec(last_mvec),
    .best_sad(best_sad), .best_mvec(best_mvec),
    .runs_done(runs_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ME core model: auto mode acks after me_delay req cycles, manual mode
  // passes the man_* values straight through
  logic              me_en = 1'b0;
  int                me_delay = 10;
  int                m_cnt = 0;
  int                m_idx = 0;
  logic              m_ack = 1'b0;
  logic [SAD_W-1:0]  m_sad = '0;
  logic [MVEC_W-1:0] m_mvec = '0;
  logic              man_ack = 1'b0;
  logic [SAD_W-1:0]  man_sad = '0;
  logic [MVEC_W-1:0] man_mvec = '0;
  logic [SAD_W-1:0]  sad_tab [0:3];
  logic [MVEC_W-1:0] mvec_tab [0:3];

  assign bus.ack      = me_en ? m_ack  : man_ack;
  assign bus.min_sad  = me_en ? m_sad  : man_sad;
  assign bus.min_mvec = me_en ? m_mvec : man_mvec;

  always @(negedge clk) begin
    if (me_en) begin
      if (bus.req && !m_ack) begin
        m_cnt = m_cnt + 1;
        if (m_cnt >= me_delay) begin
          m_ack  = 1'b1;
          m_sad  = sad_tab[m_idx];
          m_mvec = mvec_tab[m_idx];
          m_idx  = (m_idx + 1) % 4;
          m_cnt  = 0;
        end
      end else if (!bus.req && m_ack) begin
        m_ack = 1'b0;
      end
    end else begin
      m_ack = 1'b0;
      m_cnt = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Lets a released button settle through the debouncer
  task automatic settle();
    repeat (DEB + 8) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_n = '1; run_cnt = '0;
    repeat (3) tick();
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", bus.req); end
    n_checks++; if (best_sad !== 16'hFFFF) begin n_fail++; $display("FAIL rst_best_sad got %h want ffff", best_sad); end
    n_checks++; if (last_sad !== 16'h0 || last_mvec !== 12'h0 || best_mvec !== 12'h0) begin n_fail++; $display("FAIL rst_results got %h/%h/%h want 0", last_sad, last_mvec, best_mvec); end
    n_checks++; if (runs_done !== 8'h0 || busy !== 1'b0 || timeout_err !== 1'b0 || sw_fall !== 4'h0) begin n_fail++; $display("FAIL rst_status got %h/%b/%b/%h want 0", runs_done, busy, timeout_err, sw_fall); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0 || bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_release busy=%b req=%b want 0", busy, bus.req); end
  endtask

  task automatic test_debounce();
    int pulses;
    int at;
    bit seen;
    run_cnt = 8'd1; me_en = 1'b0; man_ack = 1'b0;
    // 3-cycle glitch must be rejected
    sw_n[0] = 1'b0;
    repeat (3) tick();
    sw_n[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (sw_fall[0]) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    // bounce 0-1 then final falling edge
    sw_n[0] = 1'b0; tick();
    sw_n[0] = 1'b1; tick();
    sw_n[0] = 1'b0;
    pulses = 0; at = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (sw_fall[0]) begin pulses++; at = k; end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
    n_checks++; if (at !== DEB + 3) begin n_fail++; $display("FAIL bounce_latency got %0d want %0d", at, DEB + 3); end
    // the press started a batch that can only time out
    sw_n[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); if (!busy) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL deb_batch_end got busy=1 want 0 within 100 cycles"); end
    settle();
  endtask

  task automatic test_timeout();
    int  req_cyc;
    bit  was_busy;
    bit  ended;
    bit  seen;
    run_cnt = 8'd1; me_en = 1'b0; man_ack = 1'b0;
    sw_n[0] = 1'b0;
    req_cyc = 0; was_busy = 1'b0; ended = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 12) sw_n[0] = 1'b1;
      if (bus.req) req_cyc++;
      if (busy) was_busy = 1'b1;
      else if (was_busy) begin ended = 1'b1; break; end
    end
    n_checks++; if (!ended) begin n_fail++; $display("FAIL tout_idle got busy=%b want return to idle", busy); end
    n_checks++; if (req_cyc !== TOUT) begin n_fail++; $display("FAIL tout_req_cycles got %0d want %0d", req_cyc, TOUT); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tout_err got %b want 1", timeout_err); end
    n_checks++; if (runs_done !== 8'd0) begin n_fail++; $display("FAIL tout_runs got %0d want 0", runs_done); end
    settle();
    // a new start clears the sticky flag
    sw_n[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (sw_fall[0]) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL tout_restart_pulse got none want pulse"); end
    tick();
    n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tout_cleared got err=%b busy=%b want 0/1", timeout_err, busy); end
    sw_n[0] = 1'b1;
    // end the batch with abort
    sw_n[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin tick(); if (!busy) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL tout_abort_end got busy=1 want 0"); end
    sw_n[1] = 1'b1;
    settle();
  endtask

  task automatic test_batch();
    int  rises;
    bit  prev_req;
    bit  was_busy;
    bit  ended;
    sad_tab[0] = 16'd500; mvec_tab[0] = 12'h011;
    sad_tab[1] = 16'd200; mvec_tab[1] = 12'h022;
    sad_tab[2] = 16'd200; mvec_tab[2] = 12'h033;
    sad_tab[3] = 16'd999; mvec_tab[3] = 12'h0FF;
    m_idx = 0; me_delay = 10; run_cnt = 8'd3; me_en = 1'b1;
    sw_n[0] = 1'b0;
    rises = 0; prev_req = 1'b0; was_busy = 1'b0; ended = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (i == 12) sw_n[0] = 1'b1;
      if (bus.req && !prev_req) rises++;
      prev_req = bus.req;
      if (busy) was_busy = 1'b1;
      else if (was_busy) begin ended = 1'b1; break; end
    end
    n_checks++; if (!ended) begin n_fail++; $display("FAIL batch_end got busy=%b want 0", busy); end
    n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL batch_busy_vs_ack got ack=%b want 0 when busy falls", bus.ack); end
    n_checks++; if (rises !== 3) begin n_fail++; $display("FAIL batch_req_pulses got %0d want 3", rises); end
    n_checks++; if (runs_done !== 8'd3) begin n_fail++; $display("FAIL batch_runs got %0d want 3", runs_done); end
    n_checks++; if (last_sad !== 16'd200 || last_mvec !== 12'h033) begin n_fail++; $display("FAIL batch_last got %0d/%h want 200/033", last_sad, last_mvec); end
    n_checks++; if (best_sad !== 16'd200 || best_mvec !== 12'h022) begin n_fail++; $display("FAIL batch_best got %0d/%h want 200/022", best_sad, best_mvec); end
    me_en = 1'b0;
    settle();
  endtask

  task automatic test_abort();
    logic [SAD_W-1:0]  ls;
    logic [MVEC_W-1:0] lm;
    bit seen;
    ls = last_sad; lm = last_mvec;
    run_cnt = 8'd0; me_en = 1'b0; man_ack = 1'b0;
    sw_n[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.req) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_req_rise got req=0 want 1"); end
    sw_n[0] = 1'b1;
    sw_n[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (sw_fall[1]) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_pulse got none want pulse"); end
    // ack lands in the same cycle the abort pulse is seen
    man_ack = 1'b1; man_sad = 16'h0123; man_mvec = 12'h321;
    tick();
    n_checks++; if (bus.req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_req_drop got req=%b busy=%b want 0/1", bus.req, busy); end
    n_checks++; if (runs_done !== 8'd0 || last_sad !== ls || last_mvec !== lm) begin n_fail++; $display("FAIL abort_no_capture got %0d/%h/%h want 0/%h/%h", runs_done, last_sad, last_mvec, ls, lm); end
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1 || bus.req !== 1'b0) begin n_fail++; $display("FAIL abort_hold got busy=%b req=%b want 1/0", busy, bus.req); end
    man_ack = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%b want 0", busy); end
    n_checks++; if (best_sad !== 16'hFFFF || runs_done !== 8'd0) begin n_fail++; $display("FAIL abort_best got %h/%0d want ffff/0", best_sad, runs_done); end
    sw_n[1] = 1'b1;
    settle();
  endtask

  task automatic test_start_clear();
    bit seen;
    bit ended;
    // last_sad still holds the batch value (200)
    sad_tab[0] = 16'd300; mvec_tab[0] = 12'h044;
    sad_tab[1] = 16'd100; mvec_tab[1] = 12'h055;
    m_idx = 0; me_delay = 10; run_cnt = 8'd2; me_en = 1'b1;
    sw_n[0] = 1'b0; sw_n[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (sw_fall[0]) begin seen = 1'b1; break; end end
    n_checks++; if (!seen || sw_fall[2] !== 1'b1) begin n_fail++; $display("FAIL sc_pulses got start=%b clear=%b want 1/1", seen, sw_fall[2]); end
    tick();
    n_checks++; if (busy !== 1'b1 || last_sad !== 16'd200) begin n_fail++; $display("FAIL sc_start_wins got busy=%b last=%0d want 1/200", busy, last_sad); end
    sw_n[0] = 1'b1; sw_n[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); if (runs_done == 8'd1) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL sc_first_run got runs=%0d want 1", runs_done); end
    // start while busy
    sw_n[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (sw_fall[0]) begin seen = 1'b1; break; end end
    tick();
    n_checks++; if (!seen || runs_done !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL sc_busy_start got pulse=%b runs=%0d busy=%b want 1/1/1", seen, runs_done, busy); end
    sw_n[0] = 1'b1;
    ended = 1'b0;
    for (int i = 0; i < 200; i++) begin tick(); if (!busy) begin ended = 1'b1; break; end end
    n_checks++; if (!ended || runs_done !== 8'd2) begin n_fail++; $display("FAIL sc_batch got end=%b runs=%0d want 1/2", ended, runs_done); end
    n_checks++; if (best_sad !== 16'd100 || best_mvec !== 12'h055 || last_sad !== 16'd100) begin n_fail++; $display("FAIL sc_results got best=%0d/%h last=%0d want 100/055/100", best_sad, best_mvec, last_sad); end
    me_en = 1'b0;
    settle();
    // clear alone in IDLE
    sw_n[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (sw_fall[2]) begin seen = 1'b1; break; end end
    tick();
    n_checks++; if (!seen || last_sad !== 16'd0 || last_mvec !== 12'd0 || best_sad !== 16'hFFFF || best_mvec !== 12'd0 || runs_done !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_idle got %h/%h/%h/%h/%0d/%b want 0/0/ffff/0/0/0", last_sad, last_mvec, best_sad, best_mvec, runs_done, busy);
    end
    sw_n[2] = 1'b1;
    settle();
  endtask

  task automatic test_reset_in_rel();
    bit seen;
    run_cnt = 8'd1; me_en = 1'b0; man_ack = 1'b0;
    sw_n[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.req) begin seen = 1'b1; break; end end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rrel_req got req=0 want 1"); end
    sw_n[0] = 1'b1;
    man_ack = 1'b1; man_sad = 16'h0777; man_mvec = 12'h0AB;
    tick();
    n_checks++; if (bus.req !== 1'b0 || runs_done !== 8'd1 || last_sad !== 16'h0777) begin n_fail++; $display("FAIL rrel_capture got req=%b runs=%0d last=%h want 0/1/0777", bus.req, runs_done, last_sad); end
    settle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.req !== 1'b0 || busy !== 1'b0 || best_sad !== 16'hFFFF) begin n_fail++; $display("FAIL rrel_async got req=%b busy=%b best=%h want 0/0/ffff", bus.req, busy, best_sad); end
    n_checks++; if (last_sad !== 16'h0 || last_mvec !== 12'h0 || runs_done !== 8'h0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rrel_async_out got %h/%h/%0d/%b want 0", last_sad, last_mvec, runs_done, timeout_err); end
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    n_checks++; if (runs_done !== 8'd0 || last_sad !== 16'h0 || bus.req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rrel_held_ack got runs=%0d last=%h req=%b busy=%b want 0", runs_done, last_sad, bus.req, busy); end
    man_ack = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sw_n = '1; run_cnt = '0;
    test_reset();
    test_debounce();
    test_timeout();
    test_batch();
    test_abort();
    test_start_clear();
    test_reset_in_rel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
